// File: rtl/riscv_wb_pkg.sv
// Shared types and sizes for the write-back scoreboard slice.
package riscv_wb_pkg;

  localparam int WB_ADDR_WIDTH = 5;
  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_CNT_WIDTH  = 2;

  localparam int NUM_WORDS = 2 ** WB_ADDR_WIDTH;
  localparam int CNT_MAX   = 2 ** WB_CNT_WIDTH - 1;

  // One captured result waiting in the write-back stage
  typedef struct packed {
    logic                     valid;
    logic [WB_ADDR_WIDTH-1:0] rd;
    logic [WB_DATA_WIDTH-1:0] wdata;
  } wb_req_t;

endpackage

// File: rtl/riscv_wb_counter.sv
// Saturating pending-claim counter for one architectural register.
// Accepts one claim and up to two releases per cycle; clamps at 0 and CNT_MAX.
module riscv_wb_counter
  import riscv_wb_pkg::*;
#(
  parameter int CNT_WIDTH = WB_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic [1:0]           dec_cnt,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 busy_o,
  output logic                 underflow_o
);

  localparam int CMAX = 2 ** CNT_WIDTH - 1;
  localparam logic signed [CNT_WIDTH+1:0] CMAX_S = (CNT_WIDTH + 2)'(CMAX);

  logic [CNT_WIDTH-1:0]        cnt_q;
  logic signed [CNT_WIDTH+1:0] diff;

  // Clamp a signed raw count into the legal counter range
  function automatic logic [CNT_WIDTH-1:0] sat_cnt(input logic signed [CNT_WIDTH+1:0] v);
    if (v[CNT_WIDTH+1])  sat_cnt = '0;
    else if (v > CMAX_S) sat_cnt = CMAX_S[CNT_WIDTH-1:0];
    else                 sat_cnt = v[CNT_WIDTH-1:0];
  endfunction

  // Raw next count: claim adds one, each release removes one
  always_comb begin
    diff = $signed({2'b00, cnt_q})
         + $signed({{(CNT_WIDTH + 1){1'b0}}, inc})
         - $signed({{CNT_WIDTH{1'b0}}, dec_cnt});
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= sat_cnt(diff);
  end

  assign cnt_o       = cnt_q;
  assign busy_o      = |cnt_q;
  assign underflow_o = diff[CNT_WIDTH+1];

endmodule

// File: rtl/riscv_wb_scoreboard.sv
// Write-back initiator and destination-register scoreboard.
// ALU results drive RF port A, LSU results port B, both through one
// registered stage. Per-register counters track outstanding claims and
// drop when the corresponding RF write commits, so busy_o clears only
// once the data is readable.
// Optional checker: define RISCV_WB_SCOREBOARD_CHECK_EN to enable err_o.
module riscv_wb_scoreboard
  import riscv_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int CNT_WIDTH  = WB_CNT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid_i,
  input  logic [ADDR_WIDTH-1:0]      issue_rd_i,
  output logic                       issue_ready_o,
  input  logic                       alu_valid_i,
  input  logic [ADDR_WIDTH-1:0]      alu_rd_i,
  input  logic [DATA_WIDTH-1:0]      alu_wdata_i,
  input  logic                       lsu_valid_i,
  input  logic [ADDR_WIDTH-1:0]      lsu_rd_i,
  input  logic [DATA_WIDTH-1:0]      lsu_wdata_i,
  output logic                       we_a_o,
  output logic [ADDR_WIDTH-1:0]      waddr_a_o,
  output logic [DATA_WIDTH-1:0]      wdata_a_o,
  output logic                       we_b_o,
  output logic [ADDR_WIDTH-1:0]      waddr_b_o,
  output logic [DATA_WIDTH-1:0]      wdata_b_o,
  output logic [2**ADDR_WIDTH-1:0]   busy_o,
  output logic                       err_o
);

  localparam int NWORDS = 2 ** ADDR_WIDTH;
  localparam int CMAX   = 2 ** CNT_WIDTH - 1;

  logic [CNT_WIDTH-1:0] cnt [NWORDS];
  logic [NWORDS-1:0]    busy_vec;
  logic [NWORDS-1:0]    uflow_vec;
  logic                 claim;

  wb_req_t req_a_p1;
  wb_req_t req_b_p1;
  logic    collide_p1;

  // rd=0 is never tracked, so it is always ready
  assign issue_ready_o = !((issue_rd_i != '0) && (cnt[issue_rd_i] == CNT_WIDTH'(CMAX)));
  assign claim         = issue_valid_i && issue_ready_o && (issue_rd_i != '0);

  // One counter per register; x0 is hard-wired idle
  for (genvar r = 0; r < NWORDS; r++) begin : g_cnt
    if (r == 0) begin : g_zero
      assign cnt[r]       = '0;
      assign busy_vec[r]  = 1'b0;
      assign uflow_vec[r] = 1'b0;
    end else begin : g_reg
      logic       inc;
      logic [1:0] dec;
      // Both captured results release, even when the LSU write is suppressed
      assign inc = claim && (issue_rd_i == ADDR_WIDTH'(r));
      assign dec = {1'b0, req_a_p1.valid && (req_a_p1.rd == ADDR_WIDTH'(r))}
                 + {1'b0, req_b_p1.valid && (req_b_p1.rd == ADDR_WIDTH'(r))};
      riscv_wb_counter #(
        .CNT_WIDTH (CNT_WIDTH)
      ) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .inc         (inc),
        .dec_cnt     (dec),
        .cnt_o       (cnt[r]),
        .busy_o      (busy_vec[r]),
        .underflow_o (uflow_vec[r])
      );
    end
  end

  // ---- stage p0 -> p1: capture results into the write-back registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      req_a_p1   <= '0;
      req_b_p1   <= '0;
      collide_p1 <= 1'b0;
    end else begin
      req_a_p1.valid <= alu_valid_i && (alu_rd_i != '0);
      req_a_p1.rd    <= alu_rd_i;
      req_a_p1.wdata <= alu_wdata_i;
      req_b_p1.valid <= lsu_valid_i && (lsu_rd_i != '0);
      req_b_p1.rd    <= lsu_rd_i;
      req_b_p1.wdata <= lsu_wdata_i;
      // The LSU result is older; the younger ALU value must be the one that lands
      collide_p1     <= alu_valid_i && lsu_valid_i && (alu_rd_i == lsu_rd_i) && (alu_rd_i != '0);
    end
  end

  assign we_a_o    = req_a_p1.valid;
  assign waddr_a_o = req_a_p1.rd;
  assign wdata_a_o = req_a_p1.wdata;
  assign we_b_o    = req_b_p1.valid && !collide_p1;
  assign waddr_b_o = req_b_p1.rd;
  assign wdata_b_o = req_b_p1.wdata;
  assign busy_o    = busy_vec;

`ifdef RISCV_WB_SCOREBOARD_CHECK_EN
  logic err_q;
  logic cap_err;

  // A result arriving for a register with no outstanding claim is a protocol error
  always_comb begin
    cap_err = 1'b0;
    if (alu_valid_i && (alu_rd_i != '0) && (cnt[alu_rd_i] == '0) &&
        !(claim && (issue_rd_i == alu_rd_i)))
      cap_err = 1'b1;
    if (lsu_valid_i && (lsu_rd_i != '0) && (cnt[lsu_rd_i] == '0) &&
        !(claim && (issue_rd_i == lsu_rd_i)))
      cap_err = 1'b1;
  end

  // Sticky error flag
  always_ff @(posedge clk) begin
    if (rst)                        err_q <= 1'b0;
    else if (cap_err || |uflow_vec) err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  logic uflow_unused;
  assign uflow_unused = |uflow_vec;
  assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_wb_scoreboard.sv
// Randomized self-checking bench for riscv_wb_scoreboard with a
// count-per-register reference model.
module tb_riscv_wb_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_i;
  logic        issue_ready_o;
  logic        alu_valid_i;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_wdata_i;
  logic        lsu_valid_i;
  logic [4:0]  lsu_rd_i;
  logic [31:0] lsu_wdata_i;
  logic        we_a_o, we_b_o;
  logic [4:0]  waddr_a_o, waddr_b_o;
  logic [31:0] wdata_a_o, wdata_b_o;
  logic [31:0] busy_o;
  logic        err_o;

  riscv_wb_scoreboard dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid_i (issue_valid_i),
    .issue_rd_i    (issue_rd_i),
    .issue_ready_o (issue_ready_o),
    .alu_valid_i   (alu_valid_i),
    .alu_rd_i      (alu_rd_i),
    .alu_wdata_i   (alu_wdata_i),
    .lsu_valid_i   (lsu_valid_i),
    .lsu_rd_i      (lsu_rd_i),
    .lsu_wdata_i   (lsu_wdata_i),
    .we_a_o        (we_a_o),
    .waddr_a_o     (waddr_a_o),
    .wdata_a_o     (wdata_a_o),
    .we_b_o        (we_b_o),
    .waddr_b_o     (waddr_b_o),
    .wdata_b_o     (wdata_b_o),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding claims per register and the pending writes
  int          m_cnt [32];
  logic        m_we_a, m_bcap, m_we_b, m_err;
  logic [4:0]  m_wa, m_wb;
  logic [31:0] m_da, m_db;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_we_a = 0; m_bcap = 0; m_we_b = 0; m_err = 0;
    m_wa = 0; m_wb = 0; m_da = 0; m_db = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_step();
    int   rel [32];
    int   clm [32];
    logic claim;
    if (rst) begin
      model_reset();
      return;
    end
    for (int r = 0; r < 32; r++) begin rel[r] = 0; clm[r] = 0; end
    claim = issue_valid_i && issue_rd_i != 0 && m_cnt[issue_rd_i] < 3;
    if (claim) clm[issue_rd_i] = 1;
    if (m_we_a) rel[m_wa]++;
    if (m_bcap) rel[m_wb]++;
`ifdef RISCV_WB_SCOREBOARD_CHECK_EN
    if (alu_valid_i && alu_rd_i != 0 && m_cnt[alu_rd_i] + clm[alu_rd_i] == 0) m_err = 1;
    if (lsu_valid_i && lsu_rd_i != 0 && m_cnt[lsu_rd_i] + clm[lsu_rd_i] == 0) m_err = 1;
    for (int r = 1; r < 32; r++)
      if (m_cnt[r] + clm[r] < rel[r]) m_err = 1;
`endif
    for (int r = 1; r < 32; r++) begin
      m_cnt[r] = m_cnt[r] + clm[r] - rel[r];
      if (m_cnt[r] < 0) m_cnt[r] = 0;
    end
    m_we_a = alu_valid_i && alu_rd_i != 0;
    m_wa   = alu_rd_i;
    m_da   = alu_wdata_i;
    m_bcap = lsu_valid_i && lsu_rd_i != 0;
    m_we_b = m_bcap && !(m_we_a && alu_rd_i == lsu_rd_i);
    m_wb   = lsu_rd_i;
    m_db   = lsu_wdata_i;
  endtask

  task automatic compare_all();
    logic [31:0] exp_busy;
    logic        exp_ready;
    exp_busy = '0;
    for (int r = 1; r < 32; r++) exp_busy[r] = (m_cnt[r] != 0);
    exp_ready = !(issue_rd_i != 0 && m_cnt[issue_rd_i] == 3);
    check("ready", issue_ready_o, exp_ready);
    check("we_a", we_a_o, m_we_a);
    check("we_b", we_b_o, m_we_b);
    if (m_we_a) begin
      check("waddr_a", waddr_a_o, m_wa);
      check("wdata_a", wdata_a_o, m_da);
    end
    if (m_we_b) begin
      check("waddr_b", waddr_b_o, m_wb);
      check("wdata_b", wdata_b_o, m_db);
    end
    check("busy", busy_o, exp_busy);
    check("err", err_o, m_err);
  endtask

  // Apply inputs, compare on the falling edge, then step the model on the rising edge
  task automatic cycle(input logic r, input logic iv, input logic [4:0] ird,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    rst = r; issue_valid_i = iv; issue_rd_i = ird;
    alu_valid_i = av; alu_rd_i = ard; alu_wdata_i = ad;
    lsu_valid_i = lv; lsu_rd_i = lrd; lsu_wdata_i = ld;
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic issue(input logic [4:0] rd);
    cycle(0, 1, rd, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    rst = 1; issue_valid_i = 0; issue_rd_i = 0;
    alu_valid_i = 0; alu_rd_i = 0; alu_wdata_i = 0;
    lsu_valid_i = 0; lsu_rd_i = 0; lsu_wdata_i = 0;
    @(posedge clk); #1;
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_busy", busy_o, 32'h0);
    check("rst_we", {we_a_o, we_b_o}, 2'b00);
    check("rst_waddr_wdata", {waddr_a_o, wdata_a_o, waddr_b_o}, '0);

    // Basic ALU write-back
    issue(5);
    cycle(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    check("basic_we_a", we_a_o, 1'b1);
    check("basic_waddr", waddr_a_o, 5'd5);
    check("basic_wdata", wdata_a_o, 32'hDEADBEEF);
    check("basic_busy_hold", busy_o[5], 1'b1);
    idle();
    check("basic_busy_clear", busy_o[5], 1'b0);

    // Dual write to different registers
    issue(3);
    issue(7);
    cycle(0, 0, 0, 1, 3, 32'h11, 1, 7, 32'h22);
    check("dual_we", {we_a_o, we_b_o}, 2'b11);
    check("dual_data", {wdata_a_o, wdata_b_o}, {32'h11, 32'h22});
    idle();
    check("dual_busy_clear", {busy_o[3], busy_o[7]}, 2'b00);

    // Same-register collision: ALU value wins, both claims released
    issue(9);
    issue(9);
    cycle(0, 0, 0, 1, 9, 32'hA, 1, 9, 32'hB);
    check("coll_we", {we_a_o, we_b_o}, 2'b10);
    check("coll_wdata", wdata_a_o, 32'hA);
    idle();
    check("coll_busy_clear", busy_o[9], 1'b0);

    // Saturation on x4
    issue(4);
    issue(4);
    issue(4);
    issue_valid_i = 1; issue_rd_i = 4; #1;
    check("sat_ready_low", issue_ready_o, 1'b0);
    issue(4);
    cycle(0, 0, 4, 1, 4, 32'h44, 0, 0, 0);
    check("sat_ready_during_wr", issue_ready_o, 1'b0);
    cycle(0, 0, 4, 0, 0, 0, 0, 0, 0);
    check("sat_ready_after_wr", issue_ready_o, 1'b1);

    // x0 results never write
    cycle(0, 0, 0, 1, 0, 32'h12345678, 0, 0, 0);
    check("x0_no_write", we_a_o, 1'b0);
    check("x0_busy", busy_o[0], 1'b0);

    // Reset in the middle of traffic with cnt[5]=2
    issue(5);
    issue(5);
    cycle(1, 1, 5, 1, 5, 32'h55, 0, 0, 0);
    cycle(1, 1, 6, 0, 0, 0, 1, 5, 32'h66);
    check("mid_rst_busy", busy_o, 32'h0);
    check("mid_rst_we", {we_a_o, we_b_o}, 2'b00);
    check("mid_rst_err", err_o, 1'b0);

    // Unclaimed LSU result
    cycle(0, 0, 0, 0, 0, 0, 1, 12, 32'hC0FFEE);
    idle();
    idle();
`ifdef RISCV_WB_SCOREBOARD_CHECK_EN
    check("err_sticky", err_o, 1'b1);
`else
    check("err_tied", err_o, 1'b0);
`endif
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("err_rst", err_o, 1'b0);

    // Randomized traffic on a small register window to force hazards
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 99) == 0,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom);
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
